mem_arbiter: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// owner codes and the access latency counter width.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int CNT_W = 4;

  // Counter reload value for a given memory latency.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch (IF) and data (DM) ports.
// Optional feature macro: ARB_RR_EN (round-robin on ties; otherwise DM wins).
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_owner,
  output logic owner,
  output logic any
);

`ifdef ARB_RR_EN
  // Round-robin: on a tie the port that did not own the last access wins.
  always_comb begin
    any   = if_req | dm_req;
    owner = OWN_IF;
    if (if_req && dm_req) begin
      owner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (dm_req) begin
      owner = OWN_DM;
    end else begin
      owner = OWN_IF;
    end
  end
`else
  // Fixed priority has no history; the flag is intentionally ignored.
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner;

  // Fixed priority: data port beats fetch port on a tie.
  always_comb begin
    any   = if_req | dm_req;
    owner = OWN_IF;
    if (dm_req) begin
      owner = OWN_DM;
    end else begin
      owner = OWN_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the CPU fetch port (IF)
// and data port (DM). One access at a time: IDLE -> ACCESS (MEM_LAT cycles)
// -> DONE (valid pulse) -> IDLE.
// Optional feature macro: ARB_RR_EN (round-robin tie breaking).
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

  state_t          state_r;
  state_t          state_nxt_s;
  logic            owner_r;
  logic [AW-3:0]   word_addr_r;
  logic            we_r;
  logic [DW-1:0]   wdata_r;
  logic [CNT_W-1:0] cnt_r;
  logic [DW-1:0]   if_rdata_r;
  logic [DW-1:0]   dm_rdata_r;
  logic            last_owner_s;
  logic            pick_owner_s;
  logic            pick_any_s;
  logic            grant_s;
  logic            done_cap_s;

  // Byte-offset bits never reach the memory; the access is word aligned.
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^{if_addr[1:0], dm_addr[1:0]};

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner_s),
    .owner      (pick_owner_s),
    .any        (pick_any_s)
  );

`ifdef ARB_RR_EN
  logic last_owner_r;

  // Remember who was granted last so ties alternate; reset favours DM first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_r <= OWN_IF;
    end else if (grant_s) begin
      last_owner_r <= pick_owner_s;
    end
  end

  assign last_owner_s = last_owner_r;
`else
  assign last_owner_s = OWN_IF;
`endif

  // FSM state register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and output decode; grants are suppressed while reset is low.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    done_cap_s  = 1'b0;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if_valid    = 1'b0;
    dm_valid    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {AW{1'b0}};
    mem_wdata   = {DW{1'b0}};
    busy        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s && reset) begin
          grant_s     = 1'b1;
          if_gnt      = (pick_owner_s == OWN_IF);
          dm_gnt      = (pick_owner_s == OWN_DM);
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_r;
        mem_addr  = {word_addr_r, 2'b00};
        mem_wdata = wdata_r;
        if (cnt_r == {CNT_W{1'b0}}) begin
          done_cap_s  = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        if_valid    = (owner_r == OWN_IF);
        dm_valid    = (owner_r == OWN_DM);
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Capture the winning request at grant and count down the access latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r     <= OWN_IF;
      word_addr_r <= {(AW-2){1'b0}};
      we_r        <= 1'b0;
      wdata_r     <= {DW{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else if (grant_s) begin
      owner_r     <= pick_owner_s;
      word_addr_r <= (pick_owner_s == OWN_DM) ? dm_addr[AW-1:2] : if_addr[AW-1:2];
      we_r        <= (pick_owner_s == OWN_DM) & dm_we;
      wdata_r     <= (pick_owner_s == OWN_DM) ? dm_wdata : {DW{1'b0}};
      cnt_r       <= LAT_LOAD;
    end else if ((state_r == ST_ACCESS) && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Per-port read data; holds until that port completes another access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_r <= {DW{1'b0}};
      dm_rdata_r <= {DW{1'b0}};
    end else if (done_cap_s) begin
      if (owner_r == OWN_IF) begin
        if_rdata_r <= mem_rdata;
      end else begin
        dm_rdata_r <= we_r ? {DW{1'b0}} : mem_rdata;
      end
    end
  end

  assign if_rdata = if_rdata_r;
  assign dm_rdata = dm_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table + scoreboard for single
// transactions, hand-written sequences for reset, ties, round-robin and
// MEM_LAT=1 timing.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic        b_if_gnt, b_if_valid, b_dm_gnt, b_dm_valid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;

  mem_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_valid(b_dm_valid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
    logic        exp_we;
  } vec_t;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs[5];
  sb_t         sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_if = 32'h0;
  logic [31:0] last_dm = 32'h0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge right after inputs are driven; polls for the grant.
  task automatic wait_gnt(input logic want_dm, output int t_g);
    int n;
    n = 0;
    #1;
    while (((want_dm ? dm_gnt : if_gnt) !== 1'b1) && (n < 40)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk1("gnt_seen", want_dm ? dm_gnt : if_gnt, 1'b1);
    chk1("gnt_exclusive", want_dm ? if_gnt : dm_gnt, 1'b0);
    t_g = cyc;
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if_valid || dm_valid) begin
      if (sb_q.size() == 0) begin
        chk32("valid_unexpected", {30'd0, if_valid, dm_valid}, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk1("valid_port_dm", dm_valid, e.is_dm);
        chk1("valid_port_if", if_valid, ~e.is_dm);
        chk32("rdata", e.is_dm ? dm_rdata : if_rdata, e.data);
        if (e.is_dm) last_dm = e.data;
        else         last_if = e.data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    logic [3:0] exp_own;

    reset = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    b_if_req = 1'b0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_if_addr = 32'h0; b_dm_addr = 32'h0; b_dm_wdata = 32'h0; b_mem_rdata = 32'h0;

    //               is_dm we    addr          wdata         rd            exp_maddr     exp_rdata     exp_we
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0042, 32'h0,         32'h2002_0005, 32'h0000_0040, 32'h2002_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0100, 32'h0,         1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0203, 32'h0,         32'hCAFE_F00D, 32'h0000_0200, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h1234_5678, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_5A5A, 32'h9999_9999, 32'h0000_0004, 32'h0,         1'b1};

    // Reset state, with requests pending
    #12;
    if_req = 1'b1; dm_req = 1'b1;
    #1;
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_dm_gnt", dm_gnt, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_dm_rdata", dm_rdata, 32'h0);
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0; reset = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_rdata = vecs[i].rd;
      dm_we     = vecs[i].we;
      dm_wdata  = vecs[i].wdata;
      if (vecs[i].is_dm) begin
        dm_req = 1'b1; dm_addr = vecs[i].addr;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      wait_gnt(vecs[i].is_dm, t0);
      sb_q.push_back('{vecs[i].is_dm, vecs[i].exp_rdata});
      @(negedge clk);
      if_req = 1'b0; dm_req = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
        chk1("acc_mem_en", mem_en, 1'b1);
        chk1("acc_busy", busy, 1'b1);
        chk32("acc_mem_addr", mem_addr, vecs[i].exp_maddr);
        chk1("acc_mem_we", mem_we, vecs[i].exp_we);
        if (vecs[i].exp_we) chk32("acc_mem_wdata", mem_wdata, vecs[i].wdata);
        @(negedge clk);
        #1;
      end
      chk1("done_mem_en", mem_en, 1'b0);
      chk1("done_busy", busy, 1'b1);
      @(negedge clk);
      #1;
      chk1("idle_busy", busy, 1'b0);
      chk32("if_rdata_hold", if_rdata, last_if);
      chk32("dm_rdata_hold", dm_rdata, last_dm);
    end
    dm_we = 1'b0;

    // Simultaneous requests: DM first, IF granted 4 cycles later
    @(negedge clk);
    mem_rdata = 32'h5555_AAAA;
    dm_addr = 32'h0000_0300; if_addr = 32'h0000_0088;
    if_req = 1'b1; dm_req = 1'b1;
    wait_gnt(1'b1, t0);
    sb_q.push_back('{1'b1, 32'h5555_AAAA});
    @(negedge clk);
    dm_req = 1'b0;
    wait_gnt(1'b0, t1);
    chk32("tie_if_gnt_delay", 32'(t1 - t0), 32'd4);
    sb_q.push_back('{1'b0, 32'h5555_AAAA});
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk32("tie_if_mem_addr", mem_addr, 32'h0000_0088);
    repeat (3) @(negedge clk);

    // Reset during the second ACCESS cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_1004; mem_rdata = 32'h7777_0000;
    wait_gnt(1'b0, t0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("pre_rst_mem_en", mem_en, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_rst_mem_en", mem_en, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_if_valid", if_valid, 1'b0);
    chk1("mid_rst_if_gnt", if_gnt, 1'b0);
    chk32("mid_rst_mem_addr", mem_addr, 32'h0);
    chk32("mid_rst_if_rdata", if_rdata, 32'h0);
    chk32("mid_rst_dm_rdata", dm_rdata, 32'h0);
    last_if = 32'h0; last_dm = 32'h0;
    @(negedge clk);
    if_req = 1'b0; reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk1("post_rst_busy", busy, 1'b0);

    // Both requests held for four grants
`ifdef ARB_RR_EN
    exp_own = 4'b0101;
`else
    exp_own = 4'b1111;
`endif
    @(negedge clk);
    mem_rdata = 32'h0BAD_F00D;
    if_addr = 32'h10; dm_addr = 32'h20;
    if_req = 1'b1; dm_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      #1;
      while (!(if_gnt || dm_gnt) && (n < 40)) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk1("held_gnt_seen", if_gnt | dm_gnt, 1'b1);
      chk1("held_owner_dm", dm_gnt, exp_own[g]);
      sb_q.push_back('{exp_own[g], 32'h0BAD_F00D});
      @(negedge clk);
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(negedge clk);

    // MEM_LAT=1 instance: dm read timing
    @(negedge clk);
    b_mem_rdata = 32'h3C3C_A5A5; b_dm_addr = 32'h0000_0044; b_dm_req = 1'b1;
    #1;
    chk1("lat1_gnt", b_dm_gnt, 1'b1);
    chk1("lat1_if_gnt", b_if_gnt, 1'b0);
    @(negedge clk);
    #1;
    chk1("lat1_mem_en", b_mem_en, 1'b1);
    chk1("lat1_mem_we", b_mem_we, 1'b0);
    chk32("lat1_mem_addr", b_mem_addr, 32'h0000_0044);
    chk32("lat1_mem_wdata", b_mem_wdata, 32'h0);
    chk1("lat1_early_valid", b_dm_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1("lat1_done_mem_en", b_mem_en, 1'b0);
    chk1("lat1_dm_valid", b_dm_valid, 1'b1);
    chk1("lat1_if_valid", b_if_valid, 1'b0);
    chk32("lat1_dm_rdata", b_dm_rdata, 32'h3C3C_A5A5);
    chk1("lat1_busy_gnt", b_dm_gnt, 1'b0);
    @(negedge clk);
    #1;
    chk1("lat1_next_gnt", b_dm_gnt, 1'b1);
    chk1("lat1_valid_pulse", b_dm_valid, 1'b0);
    b_dm_req = 1'b0;
    @(negedge clk);
    #1;
    chk1("lat1_dropped_busy", b_busy, 1'b0);
    chk32("lat1_if_rdata", b_if_rdata, 32'h0);

    chk32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
